// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: default PC width,
// instruction width, output buffer depth and the fetch control state type.
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int DEF_PC_W  = 14;  // word-address width of the PC
  localparam int INST_W    = 32;  // instruction word width
  localparam int DEF_DEPTH = 2;   // output buffer entries

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small FIFO holding fetched {inst, inst_pc} entries in program order.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   i_push       write i_data (ignored when full without a same-cycle pop)
//   i_pop        consume the head entry (ignored when empty)
//   i_flush      empty the FIFO; wins over push and pop
//   i_data       entry to write
//   o_data       head entry, zero when empty
//   o_valid      FIFO non-empty
//   o_count      number of valid entries
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter  int W     = 46,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [W-1:0]     i_data,
  output logic [W-1:0]     o_data,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop  = i_pop & (r_count != '0);
  assign w_push = i_push & ((r_count != CNT_W'(DEPTH)) | w_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order processes are evaluated in.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read after a push has written it, and the output is zeroed when empty.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end: owns the PC, issues one-cycle-latency reads to
// instruction memory, and buffers responses for decode. A redirect loads a
// new PC, flips the epoch bit and flushes the buffer so that no response
// fetched down the old path is ever delivered.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   new_pc, redirect     redirect target and strobe (wins over fetch)
//   halt                 stop issuing fetches; buffered data still drains
//   pc                   current fetch PC
//   imem_req, imem_addr  instruction memory read strobe and word address
//   imem_rdata           read data, valid the cycle after imem_req
//   inst_valid/ready     handshake with decode
//   inst, inst_pc        head instruction and its word address
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   new_pc,
  input  logic              redirect,
  input  logic              halt,
  output logic [PC_W-1:0]   pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam int ENT_W = INST_W + PC_W;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [PC_W-1:0]  r_pc;
  logic             r_epoch;
  logic             r_inflight;
  logic [PC_W-1:0]  r_inflight_pc;
  logic             r_inflight_epoch;

  logic             w_fetch;
  logic             w_pop;
  logic             w_push;
  logic             w_room;
  logic [OCC_W-1:0] w_occ;
  logic [CNT_W-1:0] w_count;
  logic [ENT_W-1:0] w_head;

  // Slots committed = buffered + in flight, less the entry leaving this
  // cycle; this lets a full-rate stream issue every cycle with DEPTH=2.
  assign w_pop  = inst_valid & inst_ready;
  assign w_occ  = {1'b0, w_count} + OCC_W'(r_inflight) - OCC_W'(w_pop);
  assign w_room = (w_occ < OCC_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    case (r_state)
      IDLE:    w_state_nxt = RUN;
      RUN: begin
        w_fetch = ~halt & ~redirect & w_room;
        if (halt) w_state_nxt = HALTED;
      end
      HALTED:  if (!halt) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc             <= '0;
      r_epoch          <= 1'b0;
      r_inflight       <= 1'b0;
      r_inflight_pc    <= '0;
      r_inflight_epoch <= 1'b0;
    end else begin
      if (redirect)     r_pc <= new_pc;
      else if (w_fetch) r_pc <= r_pc + PC_W'(1);
      if (redirect)     r_epoch <= ~r_epoch;
      r_inflight <= w_fetch;
      if (w_fetch) begin
        r_inflight_pc    <= r_pc;
        r_inflight_epoch <= r_epoch;
      end
    end
  end

  // A response is kept only if it was fetched in the current epoch and no
  // flush is happening in the cycle it arrives.
  assign w_push = r_inflight & (r_inflight_epoch == r_epoch) & ~redirect;

  fetch_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_data  ({imem_rdata, r_inflight_pc}),
    .o_data  (w_head),
    .o_valid (inst_valid),
    .o_count (w_count)
  );

  assign pc        = r_pc;
  assign imem_req  = w_fetch;
  assign imem_addr = r_pc;
  assign inst      = w_head[ENT_W-1:PC_W];
  assign inst_pc   = w_head[PC_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Instruction memory returns addr+0x100
// one cycle after a request. A scoreboard predicts the fetch address stream
// and the delivered {inst, inst_pc} sequence; a vector table covers start-up
// and back-pressure timing, and directed sequences cover redirect, PC wrap,
// halt drain/resume and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int PW = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [PW-1:0]     new_pc = '0;
  logic              redirect = 1'b0;
  logic              halt = 1'b0;
  logic [PW-1:0]     pc;
  logic              imem_req;
  logic [PW-1:0]     imem_addr;
  logic [INST_W-1:0] imem_rdata = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [INST_W-1:0] inst;
  logic [PW-1:0]     inst_pc;

  fetch_unit #(.PC_W(PW), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .new_pc     (new_pc),
    .redirect   (redirect),
    .halt       (halt),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory: data for a request is presented the following cycle.
  always @(posedge clk) begin
    imem_rdata <= (imem_req === 1'b1) ? 32'h100 + {18'b0, imem_addr} : 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_pop    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: expected entries queued at fetch issue, compared on delivery.
  typedef struct packed {
    logic [31:0]   inst;
    logic [PW-1:0] pc;
  } exp_t;

  exp_t          sb_q[$];
  logic [PW-1:0] sb_pc = '0;

  always @(negedge clk) begin
    exp_t e;
    if (inst_valid === 1'b1 && inst_ready) begin
      n_pop++;
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_inst_pc", 32'(inst_pc), 32'(e.pc));
        check("sb_inst", inst, e.inst);
      end
    end
    if (!rst_n) begin
      sb_q.delete();
      sb_pc = '0;
    end else begin
      if (imem_req === 1'b1) begin
        check("sb_fetch_addr", 32'(imem_addr), 32'(sb_pc));
        sb_q.push_back('{inst: 32'h100 + {18'b0, sb_pc}, pc: sb_pc});
        sb_pc = sb_pc + PW'(1);
      end
      if (redirect) begin
        sb_q.delete();
        sb_pc = new_pc;
      end
    end
  end

  // Vector table: reset flag and ready in, expected outputs at the negedge.
  typedef struct {
    logic          rst;
    logic          ready;
    logic          exp_req;
    logic [PW-1:0] exp_pc;
    logic          exp_valid;
    logic [PW-1:0] exp_ipc;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int       k;
    logic     found;
    logic [PW-1:0] saved_pc;
    int       pops_before;

    // Start-up with decode always ready: first valid two edges after the
    // first edge that samples rst_n high, then one instruction per cycle.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 14'd0, 1'b0, 14'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 14'd0, 1'b0, 14'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 14'd1, 1'b0, 14'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 14'd2, 1'b1, 14'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 14'd3, 1'b1, 14'd1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 14'd4, 1'b1, 14'd2};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 14'd5, 1'b1, 14'd3};
    // Decode stalled: exactly two fetches, head holds 0, then gapless drain.
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 14'd0, 1'b0, 14'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 14'd0, 1'b0, 14'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 14'd1, 1'b0, 14'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 14'd2, 1'b1, 14'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 14'd2, 1'b1, 14'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 14'd2, 1'b1, 14'd0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 14'd2, 1'b1, 14'd0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 14'd3, 1'b1, 14'd1};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 14'd4, 1'b1, 14'd2};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 14'd5, 1'b1, 14'd3};

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) reset_dut();
      else             step();
      inst_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      if (vecs[i].exp_req)
        check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_pc));
      check($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_inst_pc", i), 32'(inst_pc), 32'(vecs[i].exp_ipc));
        check($sformatf("v%0d_inst", i), inst, 32'h100 + 32'(vecs[i].exp_ipc));
      end
    end

    // Redirect while 4 is buffered (and popped this cycle) and 5 is in flight.
    step();
    redirect = 1'b1;
    new_pc   = 14'h0040;
    @(negedge clk);
    check("redir_no_fetch", 32'(imem_req), 32'd0);
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("redir_flushed", 32'(inst_valid), 32'd0);
    check("redir_pc", 32'(pc), 32'h40);
    check("redir_req", 32'(imem_req), 32'd1);
    found = 1'b0;
    for (k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) found = 1'b1;
    end
    check("redir_first_valid_seen", 32'(found), 32'd1);
    check("redir_first_inst_pc", 32'(inst_pc), 32'h40);

    // PC wrap across the top of the address space.
    step();
    redirect = 1'b1;
    new_pc   = 14'h3FFE;
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("wrap_addr0", 32'(imem_addr), 32'h3FFE);
    step();
    @(negedge clk);
    check("wrap_addr1", 32'(imem_addr), 32'h3FFF);
    step();
    @(negedge clk);
    check("wrap_addr2", 32'(imem_addr), 32'h0000);
    check("wrap_req2", 32'(imem_req), 32'd1);
    repeat (4) step();

    // Fill the buffer, then halt while decode drains it.
    inst_ready = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check("full_no_req", 32'(imem_req), 32'd0);
    check("full_valid", 32'(inst_valid), 32'd1);
    step();
    saved_pc    = sb_pc;
    pops_before = n_pop;
    halt        = 1'b1;
    inst_ready  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("halt_no_req%0d", c), 32'(imem_req), 32'd0);
      step();
    end
    check("halt_drained_two", 32'(n_pop - pops_before), 32'd2);
    check("halt_empty", 32'(inst_valid), 32'd0);
    check("halt_pc_held", 32'(pc), 32'(saved_pc));
    halt  = 1'b0;
    found = 1'b0;
    for (k = 0; k < 4 && !found; k++) begin
      @(negedge clk);
      if (imem_req === 1'b1) found = 1'b1;
      else step();
    end
    check("resume_req_seen", 32'(found), 32'd1);
    check("resume_addr", 32'(imem_addr), 32'(saved_pc));

    // One-cycle reset in the middle of a stream with a fetch in flight.
    repeat (3) step();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    step();
    @(negedge clk);
    check("rst_no_stale", 32'(inst_valid), 32'd0);
    found = 1'b0;
    for (k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) found = 1'b1;
    end
    check("rst_first_valid_seen", 32'(found), 32'd1);
    check("rst_first_inst_pc", 32'(inst_pc), 32'd0);
    check("rst_first_inst", inst, 32'h100);

    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
